// File: rtl/instr_fifo_pkg.sv
// Shared types and constants for the dual-issue instruction queue.
package instr_fifo_pkg;

    // Default queue depth; must be a power of two and at least 4.
    localparam int DEFAULT_DEPTH = 8;

    // Encoding of "addi x0, x0, 0", driven on empty decode slots.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // One fetched instruction together with its program counter.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fifo_mem.sv
// Storage array for instr_fifo: two write ports, two combinational read ports.
module instr_fifo_mem
    import instr_fifo_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we1,
    input  logic [AW-1:0]   waddr1,
    input  fetch_entry_t    wdata1,
    input  logic            we2,
    input  logic [AW-1:0]   waddr2,
    input  fetch_entry_t    wdata2,
    input  logic [AW-1:0]   raddr1,
    output fetch_entry_t    rdata1,
    input  logic [AW-1:0]   raddr2,
    output fetch_entry_t    rdata2
);

    fetch_entry_t mem_q [DEPTH];

    // Write both slots of an accepted push; the two addresses are always distinct.
    // NOTE: the data array has no reset; validity is tracked by the pointers and
    // count, so resetting it would only add a wide reset fan-out for nothing.
    always_ff @(posedge clk) begin
        if (we1) mem_q[waddr1] <= wdata1;
        if (we2) mem_q[waddr2] <= wdata2;
    end

    assign rdata1 = mem_q[raddr1];
    assign rdata2 = mem_q[raddr2];

endmodule

// File: rtl/instr_fifo.sv
// Dual-issue instruction queue feeding two decode slots through a registered
// output stage. Optional macro INSTR_FIFO_BYPASS_EN lets pushes into an empty,
// unstalled queue load the output stage directly (one-cycle latency).
module instr_fifo
    import instr_fifo_pkg::*;
#(
    parameter int          DEPTH    = DEFAULT_DEPTH,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fifo_rst,
    input  logic        fifo_stall,
    input  logic [1:0]  push_valid,
    input  logic [31:0] push_instr1,
    input  logic [31:0] push_instr2,
    input  logic [31:0] push_pc1,
    input  logic [31:0] push_pc2,
    output logic        fifo_full,
    output logic        valid1_out,
    output logic        valid2_out,
    output logic [31:0] instr1_out,
    output logic [31:0] instr2_out,
    output logic [31:0] pc1_out,
    output logic [31:0] pc2_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam fetch_entry_t IDLE_ENTRY = '{pc: RESET_PC, instr: NOP_INSTR};

    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] count_q, count_d;
    logic          valid1_q, valid1_d, valid2_q, valid2_d;
    fetch_entry_t  out1_q, out1_d, out2_q, out2_d;

    fetch_entry_t  push_e1, push_e2, head1, head2;
    logic          we1, we2, bypass_hit;
    logic [1:0]    n_push, n_pop;

    assign push_e1   = '{pc: push_pc1, instr: push_instr1};
    assign push_e2   = '{pc: push_pc2, instr: push_instr2};
    assign fifo_full = count_q > CW'(DEPTH - 2);

    instr_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk    (clk),
        .we1    (we1),
        .waddr1 (wp_q),
        .wdata1 (push_e1),
        .we2    (we2),
        .waddr2 (wp_q + AW'(1)),
        .wdata2 (push_e2),
        .raddr1 (rp_q),
        .rdata1 (head1),
        .raddr2 (rp_q + AW'(1)),
        .rdata2 (head2)
    );

    // Number of entries accepted this cycle; 2'b10 and pushes while full are dropped.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can
        // leave it unassigned and infer a latch.
        n_push = 2'd0;
        if (!fifo_full && fifo_rst) begin
            case (push_valid)
                2'b01:   n_push = 2'd1;
                2'b11:   n_push = 2'd2;
                default: n_push = 2'd0;
            endcase
        end
    end

`ifdef INSTR_FIFO_BYPASS_EN
    assign bypass_hit = (count_q == '0) && !fifo_stall && fifo_rst && (n_push != 2'd0);
`else
    assign bypass_hit = 1'b0;
`endif

    // Next-state: flush, then bypass or pop (on pre-push count), then push.
    always_comb begin
        wp_d     = wp_q;
        rp_d     = rp_q;
        count_d  = count_q;
        valid1_d = valid1_q;
        valid2_d = valid2_q;
        out1_d   = out1_q;
        out2_d   = out2_q;
        we1      = 1'b0;
        we2      = 1'b0;
        n_pop    = 2'd0;

        if (!fifo_rst) begin
            wp_d     = '0;
            rp_d     = '0;
            count_d  = '0;
            valid1_d = 1'b0;
            valid2_d = 1'b0;
            out1_d   = IDLE_ENTRY;
            out2_d   = IDLE_ENTRY;
        end else if (bypass_hit) begin
            valid1_d = 1'b1;
            out1_d   = push_e1;
            valid2_d = (n_push == 2'd2);
            out2_d   = (n_push == 2'd2) ? push_e2 : IDLE_ENTRY;
        end else begin
            if (!fifo_stall) begin
                if (count_q >= CW'(2))      n_pop = 2'd2;
                else if (count_q == CW'(1)) n_pop = 2'd1;
                valid1_d = (n_pop != 2'd0);
                valid2_d = (n_pop == 2'd2);
                out1_d   = (n_pop != 2'd0) ? head1 : IDLE_ENTRY;
                out2_d   = (n_pop == 2'd2) ? head2 : IDLE_ENTRY;
                rp_d     = rp_q + AW'(n_pop);
            end
            we1     = (n_push != 2'd0);
            we2     = (n_push == 2'd2);
            wp_d    = wp_q + AW'(n_push);
            count_d = count_q + CW'(n_push) - CW'(n_pop);
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            wp_q     <= '0;
            rp_q     <= '0;
            count_q  <= '0;
            valid1_q <= 1'b0;
            valid2_q <= 1'b0;
            out1_q   <= IDLE_ENTRY;
            out2_q   <= IDLE_ENTRY;
        end else begin
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            count_q  <= count_d;
            valid1_q <= valid1_d;
            valid2_q <= valid2_d;
            out1_q   <= out1_d;
            out2_q   <= out2_d;
        end
    end

    assign valid1_out = valid1_q;
    assign valid2_out = valid2_q;
    assign instr1_out = out1_q.instr;
    assign instr2_out = out2_q.instr;
    assign pc1_out    = out1_q.pc;
    assign pc2_out    = out2_q.pc;

endmodule

// File: tb/tb_instr_fifo.sv
// Self-checking bench for instr_fifo; a queue-based model supplies every
// expected value. Honours INSTR_FIFO_BYPASS_EN the same way the design does.
module tb_instr_fifo;
    import instr_fifo_pkg::*;

    localparam int          DEPTH    = 8;
    localparam logic [31:0] RESET_PC = 32'h0000_1000;
    localparam fetch_entry_t IDLE    = '{pc: RESET_PC, instr: NOP_INSTR};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_rst = 1'b1;
    logic        fifo_stall = 1'b0;
    logic [1:0]  push_valid = 2'b00;
    logic [31:0] push_instr1 = '0, push_instr2 = '0, push_pc1 = '0, push_pc2 = '0;
    logic        fifo_full, valid1_out, valid2_out;
    logic [31:0] instr1_out, instr2_out, pc1_out, pc2_out;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    fetch_entry_t q[$];
    logic         ev1 = 1'b0, ev2 = 1'b0;
    fetch_entry_t eo1 = IDLE, eo2 = IDLE;
    logic [31:0]  next_pc = '0;

    always #5 clk = ~clk;

    instr_fifo #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .fifo_rst    (fifo_rst),
        .fifo_stall  (fifo_stall),
        .push_valid  (push_valid),
        .push_instr1 (push_instr1),
        .push_instr2 (push_instr2),
        .push_pc1    (push_pc1),
        .push_pc2    (push_pc2),
        .fifo_full   (fifo_full),
        .valid1_out  (valid1_out),
        .valid2_out  (valid2_out),
        .instr1_out  (instr1_out),
        .instr2_out  (instr2_out),
        .pc1_out     (pc1_out),
        .pc2_out     (pc2_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Set inputs for the next edge; PCs continue the program-order sequence.
    task automatic drive(input logic r, input logic fr, input logic st, input logic [1:0] pv);
        rst         = r;
        fifo_rst    = fr;
        fifo_stall  = st;
        push_valid  = pv;
        push_pc1    = next_pc;
        push_pc2    = next_pc + 32'd4;
        push_instr1 = $urandom;
        push_instr2 = $urandom;
    endtask

    // Advance the model by one clock according to the queue's behavioural rules.
    task automatic model_edge();
        int n;
        bit byp;
        fetch_entry_t e1, e2;
        e1 = '{pc: push_pc1, instr: push_instr1};
        e2 = '{pc: push_pc2, instr: push_instr2};
        if (rst || !fifo_rst) begin
            q.delete();
            ev1 = 1'b0; ev2 = 1'b0; eo1 = IDLE; eo2 = IDLE;
            return;
        end
        n = 0;
        if (q.size() <= DEPTH - 2) n = (push_valid == 2'b01) ? 1 : (push_valid == 2'b11) ? 2 : 0;
        byp = 1'b0;
`ifdef INSTR_FIFO_BYPASS_EN
        byp = (q.size() == 0) && !fifo_stall && (n > 0);
`endif
        if (byp) begin
            ev1 = 1'b1; eo1 = e1;
            ev2 = (n == 2); eo2 = (n == 2) ? e2 : IDLE;
        end else begin
            if (!fifo_stall) begin
                ev1 = 1'b0; eo1 = IDLE; ev2 = 1'b0; eo2 = IDLE;
                if (q.size() > 0) begin ev1 = 1'b1; eo1 = q.pop_front(); end
                if (ev1 && q.size() > 0) begin ev2 = 1'b1; eo2 = q.pop_front(); end
            end
            if (n >= 1) q.push_back(e1);
            if (n == 2) q.push_back(e2);
        end
        next_pc = next_pc + 32'(4 * n);
    endtask

    // One clock: update model at the edge, then compare all outputs 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("fifo_full",  {31'd0, fifo_full},  {31'd0, q.size() > DEPTH - 2});
        check("valid1",     {31'd0, valid1_out}, {31'd0, ev1});
        check("valid2",     {31'd0, valid2_out}, {31'd0, ev2});
        check("instr1",     instr1_out, eo1.instr);
        check("instr2",     instr2_out, eo2.instr);
        check("pc1",        pc1_out,    eo1.pc);
        check("pc2",        pc2_out,    eo2.pc);
    endtask

    initial begin
        int drained;
        logic [31:0] exp_pc;

        // Reset values
        drive(1'b1, 1'b1, 1'b0, 2'b00);
        step();
        step();
        check("rst_valid1", {31'd0, valid1_out}, 32'd0);
        check("rst_pc1", pc1_out, RESET_PC);
        check("rst_instr2", instr2_out, NOP_INSTR);

        // First pair after reset
        next_pc = 32'h0;
        drive(1'b0, 1'b1, 1'b0, 2'b11);
        push_instr1 = 32'h0000_0093;
        push_instr2 = 32'h0010_0113;
        step();
`ifndef INSTR_FIFO_BYPASS_EN
        check("first_v1_early", {31'd0, valid1_out}, 32'd0);
        drive(1'b0, 1'b1, 1'b0, 2'b00);
        step();
`endif
        check("first_v1", {31'd0, valid1_out}, 32'd1);
        check("first_v2", {31'd0, valid2_out}, 32'd1);
        check("first_pc1", pc1_out, 32'h0);
        check("first_pc2", pc2_out, 32'h4);
        check("first_instr1", instr1_out, 32'h0000_0093);
        drive(1'b0, 1'b1, 1'b0, 2'b00);
        step();
        step();

        // Fill under stall: full after four pairs, fifth dropped, then drain in order
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b1, 2'b11);
            step();
            if (i == 3) check("full_after_4", {31'd0, fifo_full}, 32'd1);
        end
        exp_pc  = next_pc - 32'd32;
        drained = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, 1'b0, 2'b00);
            step();
            if (valid1_out) begin
                check("drain_order1", pc1_out, exp_pc);
                exp_pc += 4; drained++;
            end
            if (valid2_out) begin
                check("drain_order2", pc2_out, exp_pc);
                exp_pc += 4; drained++;
            end
        end
        check("drain_count", 32'(drained), 32'd8);

        // Single push into an empty queue
        next_pc = 32'h10;
        drive(1'b0, 1'b1, 1'b0, 2'b01);
        step();
`ifndef INSTR_FIFO_BYPASS_EN
        drive(1'b0, 1'b1, 1'b0, 2'b00);
        step();
`endif
        check("single_v1", {31'd0, valid1_out}, 32'd1);
        check("single_v2", {31'd0, valid2_out}, 32'd0);
        check("single_i2", instr2_out, NOP_INSTR);
        check("single_pc1", pc1_out, 32'h10);
        drive(1'b0, 1'b1, 1'b0, 2'b00);
        step();

        // Steady state at six entries across several pointer wraps
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b1, 2'b11);
            step();
        end
        exp_pc = next_pc - 32'd24;
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 1'b1, 1'b0, 2'b11);
            step();
            check("wrap_pc1", pc1_out, exp_pc);
            check("wrap_pc2", pc2_out, exp_pc + 32'd4);
            check("wrap_not_full", {31'd0, fifo_full}, 32'd0);
            exp_pc += 8;
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b0, 2'b00);
            step();
        end

        // Flush with five queued and a simultaneous push
        drive(1'b0, 1'b1, 1'b1, 2'b11); step();
        drive(1'b0, 1'b1, 1'b1, 2'b11); step();
        drive(1'b0, 1'b1, 1'b1, 2'b01); step();
        drive(1'b0, 1'b0, 1'b0, 2'b11); step();
        check("flush_v1", {31'd0, valid1_out}, 32'd0);
        check("flush_v2", {31'd0, valid2_out}, 32'd0);
        check("flush_full", {31'd0, fifo_full}, 32'd0);
        drive(1'b0, 1'b1, 1'b0, 2'b00); step();
        step();
        check("flush_empty", {31'd0, valid1_out}, 32'd0);

        // Reset asserted mid-stall with a full queue
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b1, 2'b11);
            step();
        end
        check("pre_rst_full", {31'd0, fifo_full}, 32'd1);
        drive(1'b1, 1'b1, 1'b1, 2'b11);
        step();
        check("midrst_full", {31'd0, fifo_full}, 32'd0);
        check("midrst_v1", {31'd0, valid1_out}, 32'd0);
        check("midrst_pc2", pc2_out, RESET_PC);
        check("midrst_i1", instr1_out, NOP_INSTR);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 29) != 0),
                  ($urandom_range(0, 2) == 0), 2'($urandom));
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fifo.md
# instr_fifo

Dual-issue instruction queue between the fetch/cache controller and the two decode slots. Accepts up to two fetched instructions (with PCs) per cycle and presents up to two in program order to Instr_Decode1/Instr_Decode2 through a registered output stage. Reports `fifo_full` to the Control unit. Obeys Control's `fifo_stall` (hold) and `fifo_rst` (active-low flush on taken jump).

## Interface
- `DEPTH`, 8: queue entries; power of two, ≥4.
- `RESET_PC`, 32'd0: PC value driven on output PC ports at reset and flush.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `fifo_rst`  in  1  from Control; active-low synchronous flush.
- `fifo_stall`  in  1  from Control; high = hold output stage, no pop.
- `push_valid`  in  2  bit0 = slot1 valid, bit1 = slot2 valid; 2'b10 is treated as no push.
- `push_instr1`, `push_instr2`  in  32 each  fetched instructions, slot1 older.
- `push_pc1`, `push_pc2`  in  32 each  matching PCs.
- `fifo_full`  out  1  to Control (drives `stop_fetch`).
- `valid1_out`, `valid2_out`  out  1 each  decode slot valid.
- `instr1_out`, `instr2_out`  out  32 each  decode slot instruction.
- `pc1_out`, `pc2_out`  out  32 each  decode slot PC.

## Operation
- Storage: DEPTH entries of {pc, instr}; write pointer `wp`, read pointer `rp` (log2(DEPTH) bits, wrap mod DEPTH); `count` is log2(DEPTH)+1 bits.
- `fifo_full` = `count > DEPTH-2`: combinational from registered `count`; guarantees a 2-wide push is always safe when low.
- Push (when `fifo_full`=0): 2'b01 writes slot1 at `wp`, `wp`+=1; 2'b11 writes slot1 at `wp`, slot2 at `wp+1` (mod DEPTH), `wp`+=2. Push while `fifo_full`=1 is dropped.
- Pop (when `fifo_stall`=0): output stage loads head; `count`≥2 → both slots valid, `rp`+=2; `count`==1 → slot1 only, `valid2_out`=0, `rp`+=1; `count`==0 → both valids 0. Pop sees pre-push `count` of the same cycle.
- `count_next = count + pushed − popped`; simultaneous push and pop legal at any fill level.
- `fifo_stall`=1: output regs, `rp` unchanged; pushes still accepted.
- Invalid output slot: instr = 32'h00000013 (NOP), pc = `RESET_PC`.
- Priority: `rst` > flush (`fifo_rst`=0) > stall > normal. Flush/reset: `wp`=`rp`=`count`=0, both valids 0, instrs NOP, pcs `RESET_PC`, `fifo_full`=0; push in the same cycle is dropped.

## Timing
- Reset values: all valids 0, instrs NOP, pcs `RESET_PC`, `fifo_full` 0.
- Push in cycle N into empty queue → entry visible at output in cycle N+2 (no stall).
- Flush asserted in cycle N → outputs invalid in cycle N+1; first post-flush push in N+1 appears in N+3.
- Stall for K cycles holds outputs stable K cycles; popping resumes on the first cycle with `fifo_stall`=0.
- `fifo_full` reacts one cycle after the push that fills.

## Configuration
- `INSTR_FIFO_BYPASS_EN` defined: when `count`==0, `fifo_stall`=0, no flush, pushed instructions load directly into the output stage (latency 1, N+1); queue untouched. Undefined: no bypass, latency always 2.

## Structure
- Shared package `instr_fifo_pkg`: typedef `fetch_entry_t` {pc[31:0], instr[31:0]}, constant `NOP_INSTR`=32'h00000013, default `DEPTH`.
- One sub-module `instr_fifo_mem`: DEPTH-entry register array, two write ports, two read ports (head, head+1), no reset on data.

## Test plan
- Reset, then push 2'b11 {0x00000093@0x0, 0x00100113@0x4} → cycle N+2: both valids 1, pcs 0x0/0x4 (N+1 with bypass).
- Push 2'b11 every cycle with `fifo_stall`=1, DEPTH=8 → `fifo_full`=1 after 4 pushes; further pushes dropped; releasing stall drains in order, no loss/duplication.
- Single push 2'b01 @0x10 into empty queue → `valid1_out`=1, `valid2_out`=0, `instr2_out`=NOP.
- Fill 6, pop 2/push 2 alternately across 3 wraps → output PC sequence strictly +4 monotonic, `count` constant.
- `fifo_rst`=0 with 5 entries queued and simultaneous push → next cycle valids 0, `fifo_full` 0; pushed entry absent.
- `rst`=1 asserted mid-stall with full queue → all outputs at reset values next cycle.
